uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//  Asynchronous UART receiver; companion to the UART transmitter in the same core.
//  Recovers 8N1/7N1/8P1/7P1 frames from the serial line rx using a 16x oversample tick (baud_clock).
//  Delivers bytes either to a holding register (rxrdy handshake) or to the RX FIFO (write strobe).
//  Reports parity, framing and overflow errors.
// PARAMETERS
//  RX_FIFO      0   0 = holding register + rxrdy handshake; 1 = push each received byte to the RX FIFO
// PORTS
//  clk          in   1  system clock
//  aresetn      in   1  reset, asynchronous, active-low
//  baud_clock   in   1  one-clk pulse at 16x the bit rate
//  rx           in   1  serial input, asynchronous to clk, idle high
//  bit8         in   1  1 = 8 data bits, 0 = 7 data bits
//  parity_en    in   1  1 = parity bit follows the data bits
//  odd_n_even   in   1  1 = odd parity, 0 = even parity
//  read_rx_byte in   1  one-clk pulse; consumer has read rx_dout (RX_FIFO=0 only)
//  clear_err    in   1  one-clk pulse; clears parity_err, framing_err and overflow
//  fifo_full    in   1  RX FIFO full (RX_FIFO=1 only)
//  rx_dout      out  8  last accepted byte, LSB first on the line; bit 7 = 0 in 7-bit mode
//  rxrdy        out  1  byte available in rx_dout (RX_FIFO=0); tied 0 when RX_FIFO=1
//  fifo_write_n out  1  active-low one-clk FIFO write strobe; rx_dout is valid in the same clk
//  parity_err   out  1  sticky: received parity bit did not match
//  framing_err  out  1  sticky: stop bit sampled low
//  overflow     out  1  sticky: byte dropped because rxrdy=1 or fifo_full=1
// BEHAVIOUR
//  Reset values: rx_dout=0, rxrdy=0, fifo_write_n=1, all error flags=0, state=IDLE, armed=0.
//  Input conditioning:
//   - rx passes through a 2-flop synchronizer.
//   - rx_f is the 3-tap majority of the synchronized rx, shifted on each baud_clock.
//   - All decisions below use rx_f.
//  Arming: after reset, armed=0. armed sets on the first baud_clock with rx_f=1.
//   No start bit is accepted while armed=0, so release from reset mid-frame never yields a byte.
//  4-bit sample counter cnt and all state transitions advance only on baud_clock.
//  States:
//   IDLE   : armed and rx_f=0 -> START, cnt=0.
//   START  : at cnt=7 (mid start bit), rx_f=0 -> DATA, cnt=0; rx_f=1 -> IDLE (glitch rejected, no flags).
//   DATA   : at cnt=15, shift rx_f into bit index bitcnt, bitcnt+1.
//            After bit 7 (bit8=1) or bit 6 (bit8=0) -> PARITY if parity_en, else STOP.
//   PARITY : at cnt=15, perr = rx_f ^ odd_n_even ^ (XOR of the received data bits) -> STOP.
//   STOP   : at cnt=15 (mid stop bit), do the completion step below -> IDLE in the same tick.
//            This allows back-to-back frames with no idle time.
//  Completion step:
//   - framing_err |= (rx_f==0).
//   - parity_err |= perr when parity_en=1.
//   - RX_FIFO=0: rxrdy=0 -> load rx_dout, set rxrdy. rxrdy=1 -> overflow=1; rx_dout unchanged.
//   - RX_FIFO=1: fifo_full=0 -> load rx_dout, fifo_write_n=0 for exactly 1 clk.
//                fifo_full=1 -> overflow=1, no strobe.
//   - The byte is delivered even when a framing or parity error is flagged.
//  Latency: rxrdy and fifo_write_n assert 1 clk after the baud_clock that samples mid stop bit.
//  Simultaneous events:
//   - read_rx_byte in the same clk as completion: byte loads, rxrdy stays 1, no overflow.
//   - read_rx_byte with rxrdy=0: no effect.
//   - clear_err in the same clk as a new error: the set wins.
//  bit8, parity_en and odd_n_even are sampled live. Software changes them only while idle;
//   a mid-frame change has undefined frame content, but the FSM always returns to IDLE.
// TESTING
//  8N1 byte 0xA5 at 16x ticks -> rx_dout=0xA5, rxrdy=1 one clk after the mid-stop tick, no error flags.
//  7-bit, odd parity, byte 0x41 with parity bit 1 -> rx_dout=0x41, parity_err=0.
//   Same frame with parity bit 0 -> parity_err=1 until clear_err.
//  Low pulse of 4 ticks on idle rx -> returns to IDLE, rxrdy=0, no flags.
//   Stop bit forced 0 on byte 0x3C -> rx_dout=0x3C, framing_err=1.
//  RX_FIFO=0: two frames 0x11 then 0x22 without read_rx_byte -> rx_dout=0x11, overflow=1.
//   read_rx_byte coincident with 2nd completion -> rx_dout=0x22, overflow=0.
//  RX_FIFO=1: frames 0x55, 0xAA back-to-back -> two single-clk fifo_write_n pulses with the matching rx_dout.
//   fifo_full=1 at the 2nd completion -> one strobe only, overflow=1.
//  aresetn pulsed mid-frame (bit 3 of 0xF0), released while rx=0 -> no byte, no flags.
//   Next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling, majority-filtered input and 7/8-bit, optional-parity framing.
// Delivers bytes to a holding register (rxrdy handshake) or as a one-clk FIFO write strobe.
module uart_rx_oversample #(
   parameter int unsigned RX_FIFO = 0
) (
   input  logic       clk,
   input  logic       aresetn,
   input  logic       baud_clock,
   input  logic       rx,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       read_rx_byte,
   input  logic       clear_err,
   input  logic       fifo_full,
   output logic [7:0] rx_dout,
   output logic       rxrdy,
   output logic       fifo_write_n,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [BIT_W-1:0]    r_bitcnt;
   logic [DATA_W-1:0]   r_shift;
   logic                r_perr;
   logic                r_armed;
   logic                r_rx_meta;
   logic                r_rx_sync;
   logic [2:0]          r_taps;
   logic [DATA_W-1:0]   r_rx_dout;
   logic                r_rxrdy;
   logic                r_fifo_write_n;
   logic                r_parity_err;
   logic                r_framing_err;
   logic                r_overflow;

   logic                w_rx_f;
   logic                w_last_bit;
   logic                w_mid;

   // Synchronizer and taps reset low so the receiver cannot arm until the line is seen high.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_rx_meta <= 1'b0;
         r_rx_sync <= 1'b0;
         r_taps    <= 3'b000;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         if (baud_clock) begin
            r_taps <= {r_taps[1:0], r_rx_sync};
         end
      end
   end

   assign w_rx_f     = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) | (r_taps[1] & r_taps[2]);
   assign w_last_bit = bit8 ? (r_bitcnt == BIT_W'(7)) : (r_bitcnt == BIT_W'(6));
   assign w_mid      = (r_cnt == CNT_W'(15));

   // Frame FSM; later assignments in the same clk take priority over the clears above them.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_bitcnt       <= '0;
         r_shift        <= '0;
         r_perr         <= 1'b0;
         r_armed        <= 1'b0;
         r_rx_dout      <= '0;
         r_rxrdy        <= 1'b0;
         r_fifo_write_n <= 1'b1;
         r_parity_err   <= 1'b0;
         r_framing_err  <= 1'b0;
         r_overflow     <= 1'b0;
      end else begin
         r_fifo_write_n <= 1'b1;
         if (read_rx_byte && (RX_FIFO == 0)) begin
            r_rxrdy <= 1'b0;
         end
         if (clear_err) begin
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
         end
         if (baud_clock) begin
            if (w_rx_f) begin
               r_armed <= 1'b1;
            end
            case (r_state)
               S_IDLE: begin
                  if (r_armed && !w_rx_f) begin
                     r_state <= S_START;
                     r_cnt   <= '0;
                  end
               end
               S_START: begin
                  if (r_cnt == CNT_W'(7)) begin
                     if (!w_rx_f) begin
                        r_state  <= S_DATA;
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_DATA: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_mid) begin
                     r_shift[r_bitcnt] <= w_rx_f;
                     r_bitcnt          <= r_bitcnt + BIT_W'(1);
                     if (w_last_bit) begin
                        r_state <= parity_en ? S_PARITY : S_STOP;
                     end
                  end
               end
               S_PARITY: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_mid) begin
                     r_perr  <= w_rx_f ^ odd_n_even ^ (^r_shift);
                     r_state <= S_STOP;
                  end
               end
               S_STOP: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_mid) begin
                     r_state <= S_IDLE;
                     if (!w_rx_f) begin
                        r_framing_err <= 1'b1;
                     end
                     if (parity_en && r_perr) begin
                        r_parity_err <= 1'b1;
                     end
                     if (RX_FIFO == 0) begin
                        // A read in the same clk frees the holding register for this byte.
                        if (!r_rxrdy || read_rx_byte) begin
                           r_rx_dout <= r_shift;
                           r_rxrdy   <= 1'b1;
                        end else begin
                           r_overflow <= 1'b1;
                        end
                     end else begin
                        if (!fifo_full) begin
                           r_rx_dout      <= r_shift;
                           r_fifo_write_n <= 1'b0;
                        end else begin
                           r_overflow <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign rx_dout      = r_rx_dout;
   assign rxrdy        = r_rxrdy;
   assign fifo_write_n = r_fifo_write_n;
   assign parity_err   = r_parity_err;
   assign framing_err  = r_framing_err;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: one holding-register instance and one FIFO-mode instance,
// delivered bytes checked against a per-instance scoreboard queue.
module tb_uart_rx_oversample;

   // Tick index within an 8N1 frame at which the receiver samples mid stop bit
   // (3 ticks of sync/majority delay + 8 ticks to mid start + 9 bit periods).
   localparam int COMP_8N1 = 155;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   logic baud_clock = 1'b0;
   logic rx_line = 1'b1;
   logic sel = 1'b0;
   logic bit8 = 1'b1;
   logic parity_en = 1'b0;
   logic odd_n_even = 1'b0;
   logic read_rx_byte = 1'b0;
   logic clear_err = 1'b0;
   logic fifo_full = 1'b0;
   logic rx0, rx1;

   logic [7:0] dout0, dout1;
   logic rxrdy0, rxrdy1, fwn0, fwn1, perr0, perr1, ferr0, ferr1, ovf0, ovf1;

   int checks = 0;
   int errors = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   logic prev_rxrdy0 = 1'b0;
   logic prev_fwn1 = 1'b1;
   logic baud_last = 1'b0;

   assign rx0 = sel ? 1'b1 : rx_line;
   assign rx1 = sel ? rx_line : 1'b1;

   always #5 clk = ~clk;

   uart_rx_oversample #(.RX_FIFO(0)) u_dut0 (
      .clk(clk), .aresetn(aresetn), .baud_clock(baud_clock), .rx(rx0),
      .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
      .read_rx_byte(read_rx_byte), .clear_err(clear_err), .fifo_full(fifo_full),
      .rx_dout(dout0), .rxrdy(rxrdy0), .fifo_write_n(fwn0),
      .parity_err(perr0), .framing_err(ferr0), .overflow(ovf0)
   );

   uart_rx_oversample #(.RX_FIFO(1)) u_dut1 (
      .clk(clk), .aresetn(aresetn), .baud_clock(baud_clock), .rx(rx1),
      .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
      .read_rx_byte(read_rx_byte), .clear_err(clear_err), .fifo_full(fifo_full),
      .rx_dout(dout1), .rxrdy(rxrdy1), .fifo_write_n(fwn1),
      .parity_err(perr1), .framing_err(ferr1), .overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One baud tick: baud_clock high for one clk, then three low clks.
   task automatic tick(input bit rd, input bit rst);
      if (rst) aresetn = 1'b0;
      baud_clock = 1'b1;
      read_rx_byte = rd;
      @(posedge clk); #1;
      baud_clock = 1'b0;
      read_rx_byte = 1'b0;
      aresetn = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic idle(input int n);
      rx_line = 1'b1;
      repeat (n) tick(1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pbit, input bit sbit,
                             input int rd_at, input int rst_at);
      logic [11:0] fr;
      int nb, nbits, idx;
      nb = bit8 ? 8 : 7;
      fr = '0;
      for (int i = 0; i < nb; i++) fr[1+i] = d[i];
      if (parity_en) fr[1+nb] = pbit;
      fr[1+nb+int'(parity_en)] = sbit;
      nbits = 2 + nb + int'(parity_en);
      idx = 0;
      for (int p = 0; p < nbits; p++) begin
         for (int t = 0; t < 16; t++) begin
            rx_line = fr[p];
            tick(idx == rd_at, idx == rst_at);
            idx++;
         end
      end
   endtask

   task automatic pulse_read();
      read_rx_byte = 1'b1;
      @(posedge clk); #1;
      read_rx_byte = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
   endtask

   // Output monitor: pops the scoreboard on each delivery event.
   always @(negedge clk) begin
      if (rxrdy0 && !prev_rxrdy0) begin
         chk("dut0 byte expected", 32'(q0.size() != 0), 32'd1);
         chk("dut0 rxrdy latency", 32'(baud_last), 32'd1);
         if (q0.size() != 0) chk("dut0 rx_dout", 32'(dout0), 32'(q0.pop_front()));
      end
      if (!fwn1) begin
         chk("dut1 strobe expected", 32'(q1.size() != 0), 32'd1);
         chk("dut1 strobe width", 32'(prev_fwn1), 32'd1);
         chk("dut1 strobe latency", 32'(baud_last), 32'd1);
         if (q1.size() != 0) chk("dut1 rx_dout", 32'(dout1), 32'(q1.pop_front()));
      end
      prev_rxrdy0 = rxrdy0;
      prev_fwn1 = fwn1;
      baud_last = baud_clock;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset rx_dout", 32'(dout0), 32'h00);
      chk("reset rxrdy", 32'(rxrdy0), 32'd0);
      chk("reset fifo_write_n", 32'(fwn1), 32'd1);
      chk("reset flags", 32'({perr0, ferr0, ovf0, perr1, ferr1, ovf1}), 32'd0);
      aresetn = 1'b1;
      idle(20);

      // 8N1 0xA5
      q0.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
      idle(20);
      chk("A5 delivered", 32'(q0.size()), 32'd0);
      chk("A5 rxrdy", 32'(rxrdy0), 32'd1);
      chk("A5 flags", 32'({perr0, ferr0, ovf0}), 32'd0);
      pulse_read();
      chk("read clears rxrdy", 32'(rxrdy0), 32'd0);
      pulse_read();
      chk("read with rxrdy=0", 32'({rxrdy0, ovf0}), 32'd0);

      // 7O1 0x41, good then bad parity
      bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
      q0.push_back(8'h41);
      send_frame(8'h41, 1'b1, 1'b1, -1, -1);
      idle(20);
      chk("7O1 good delivered", 32'(q0.size()), 32'd0);
      chk("7O1 good parity_err", 32'(perr0), 32'd0);
      pulse_read();
      q0.push_back(8'h41);
      send_frame(8'h41, 1'b0, 1'b1, -1, -1);
      idle(20);
      chk("7O1 bad delivered", 32'(q0.size()), 32'd0);
      chk("7O1 bad parity_err", 32'(perr0), 32'd1);
      pulse_read();
      idle(2);
      chk("parity_err sticky", 32'(perr0), 32'd1);
      pulse_clear();
      chk("parity_err cleared", 32'(perr0), 32'd0);
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;

      // 4-tick glitch on idle line
      rx_line = 1'b0;
      repeat (4) tick(1'b0, 1'b0);
      idle(30);
      chk("glitch rxrdy", 32'(rxrdy0), 32'd0);
      chk("glitch flags", 32'({perr0, ferr0, ovf0}), 32'd0);

      // stop bit low on 0x3C
      q0.push_back(8'h3C);
      send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
      idle(30);
      chk("framing delivered", 32'(q0.size()), 32'd0);
      chk("framing rx_dout", 32'(dout0), 32'h3C);
      chk("framing_err", 32'(ferr0), 32'd1);
      pulse_read();
      pulse_clear();
      chk("framing_err cleared", 32'(ferr0), 32'd0);

      // overflow: 0x11 then 0x22 unread
      q0.push_back(8'h11);
      send_frame(8'h11, 1'b0, 1'b1, -1, -1);
      send_frame(8'h22, 1'b0, 1'b1, -1, -1);
      idle(20);
      chk("overflow rx_dout", 32'(dout0), 32'h11);
      chk("overflow flag", 32'(ovf0), 32'd1);
      chk("overflow rxrdy", 32'(rxrdy0), 32'd1);
      pulse_clear();
      pulse_read();

      // read coincident with 2nd completion
      q0.push_back(8'h11);
      send_frame(8'h11, 1'b0, 1'b1, -1, -1);
      send_frame(8'h22, 1'b0, 1'b1, COMP_8N1, -1);
      idle(20);
      chk("coincident q0", 32'(q0.size()), 32'd0);
      chk("coincident rx_dout", 32'(dout0), 32'h22);
      chk("coincident rxrdy", 32'(rxrdy0), 32'd1);
      chk("coincident overflow", 32'(ovf0), 32'd0);
      pulse_read();

      // FIFO mode: back-to-back 0x55, 0xAA
      sel = 1'b1;
      idle(4);
      q1.push_back(8'h55);
      q1.push_back(8'hAA);
      send_frame(8'h55, 1'b0, 1'b1, -1, -1);
      send_frame(8'hAA, 1'b0, 1'b1, -1, -1);
      idle(20);
      chk("fifo both strobes", 32'(q1.size()), 32'd0);
      chk("fifo overflow clear", 32'(ovf1), 32'd0);
      chk("fifo rxrdy tied", 32'(rxrdy1), 32'd0);

      // FIFO full at 2nd completion
      q1.push_back(8'h55);
      send_frame(8'h55, 1'b0, 1'b1, -1, -1);
      fifo_full = 1'b1;
      send_frame(8'hAA, 1'b0, 1'b1, -1, -1);
      idle(20);
      fifo_full = 1'b0;
      chk("fifo full one strobe", 32'(q1.size()), 32'd0);
      chk("fifo full overflow", 32'(ovf1), 32'd1);
      chk("fifo full rx_dout", 32'(dout1), 32'h55);
      pulse_clear();
      chk("fifo overflow cleared", 32'(ovf1), 32'd0);

      // reset mid-frame during bit 3 of 0xF0, released while rx low
      sel = 1'b0;
      idle(4);
      send_frame(8'hF0, 1'b0, 1'b1, -1, 72);
      idle(30);
      chk("mid reset rxrdy", 32'(rxrdy0), 32'd0);
      chk("mid reset rx_dout", 32'(dout0), 32'h00);
      chk("mid reset flags", 32'({perr0, ferr0, ovf0}), 32'd0);
      q0.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
      idle(20);
      chk("after reset delivered", 32'(q0.size()), 32'd0);
      chk("after reset rx_dout", 32'(dout0), 32'h5A);
      chk("after reset flags", 32'({perr0, ferr0, ovf0}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
